// File: rtl/sum_display_scanner.sv
// rtl/sum_display_scanner.sv - 32-bit sum snapshot shown 16 bits at a time on a 4-digit 7-segment display
//
// Purpose:
//   Captures the adder sum and carry-out. Shows one 16-bit page as four hex
//   digits on a common-anode display. The display is time-multiplexed:
//   one digit is enabled at a time.
//
// Parameters:
//   REFRESH_DIV  clk cycles per digit slot (>= 2)
//   PAGE_HOLD    complete scan frames per page in auto mode (>= 1)
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   sum        adder sum
//   cout       adder carry-out
//   load       level; snapshot sum/cout on every clk where load=1
//   auto_page  1 = pages alternate automatically every PAGE_HOLD frames
//   page_sel   manual page: 0 = sum[15:0], 1 = sum[31:16]
//   seg_n      active-low segments {g,f,e,d,c,b,a}
//   an_n       active-low anodes, an_n[0] = rightmost / least significant nibble
//   dp_n       active-low decimal point (carry indicator on digit 3 of page 1)
//   page_led   current page
//
// Optional feature (macro LEADING_ZERO_BLANK_EN):
//   When the macro is defined, digits above the most significant nonzero
//   nibble of the displayed page are blanked. Their anodes still scan.
//   Digit 0 is never blanked.

module sum_display_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter int PAGE_HOLD   = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] sum,
  input  logic        cout,
  input  logic        load,
  input  logic        auto_page,
  input  logic        page_sel,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n,
  output logic        dp_n,
  output logic        page_led
);

  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int FRM_W = (PAGE_HOLD > 1) ? $clog2(PAGE_HOLD) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(PAGE_HOLD - 1);

  // State
  logic [31:0]      snap_q, snap_d;
  logic             snap_cout_q, snap_cout_d;
  logic             page_q, page_d;
  logic [1:0]       digit_q, digit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [FRM_W-1:0] frame_q, frame_d;

  // Registered display outputs
  logic [6:0]       seg_n_q, seg_n_d;
  logic [3:0]       an_n_q, an_n_d;
  logic             dp_n_q, dp_n_d;

  // Decode helpers
  logic             div_wrap;
  logic             frame_end;
  logic [15:0]      page_nibs;
  logic [3:0]       nib;
`ifdef LEADING_ZERO_BLANK_EN
  logic             lz_blank;
`endif

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  always_comb begin
    // Scan timing
    div_wrap  = (div_q == DIV_LAST);
    frame_end = div_wrap && (digit_q == 2'd3);
    div_d     = div_wrap ? '0 : div_q + 1'b1;
    digit_d   = div_wrap ? digit_q + 2'd1 : digit_q;

    // The page may change only at a frame boundary. This keeps one frame
    // from mixing digits of the two halves.
    frame_d = frame_q;
    page_d  = page_q;
    if (frame_end) begin
      if (auto_page) begin
        if (frame_q == FRM_LAST) begin
          frame_d = '0;
          page_d  = ~page_q;
        end else begin
          frame_d = frame_q + 1'b1;
        end
      end else begin
        frame_d = '0;
        page_d  = page_sel;
      end
    end

    // Snapshot
    snap_d      = load ? sum  : snap_q;
    snap_cout_d = load ? cout : snap_cout_q;

    // Digit decode. Registered outputs are computed from the current state.
    page_nibs = page_q ? snap_q[31:16] : snap_q[15:0];
    nib       = page_nibs[{digit_q, 2'b00} +: 4];

    // All anodes are off for the first cycle of each slot. This stops the
    // previous digit's segments from ghosting onto the next anode.
    an_n_d  = (div_q == '0) ? 4'b1111 : ~(4'b0001 << digit_q);
    seg_n_d = hex_glyph(nib);
`ifdef LEADING_ZERO_BLANK_EN
    // The digit is a leading zero when it and every nibble above it are zero.
    lz_blank = (digit_q != 2'd0) && ((page_nibs >> {digit_q, 2'b00}) == 16'd0);
    if (lz_blank) begin
      seg_n_d = 7'b1111111;
    end
`endif
    dp_n_d = ~((digit_q == 2'd3) && page_q && snap_cout_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_q      <= '0;
      snap_cout_q <= 1'b0;
      page_q      <= 1'b0;
      digit_q     <= 2'd0;
      div_q       <= '0;
      frame_q     <= '0;
      seg_n_q     <= 7'b1111111;
      an_n_q      <= 4'b1111;
      dp_n_q      <= 1'b1;
    end else begin
      snap_q      <= snap_d;
      snap_cout_q <= snap_cout_d;
      page_q      <= page_d;
      digit_q     <= digit_d;
      div_q       <= div_d;
      frame_q     <= frame_d;
      seg_n_q     <= seg_n_d;
      an_n_q      <= an_n_d;
      dp_n_q      <= dp_n_d;
    end
  end

  assign seg_n    = seg_n_q;
  assign an_n     = an_n_q;
  assign dp_n     = dp_n_q;
  assign page_led = page_q;

endmodule

// File: tb/tb_sum_display_scanner.sv
// tb/tb_sum_display_scanner.sv - scoreboard bench for sum_display_scanner

module tb_sum_display_scanner;

  localparam int RD = 4;
  localparam int PH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] sum;
  logic        cout;
  logic        load;
  logic        auto_page;
  logic        page_sel;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        page_led;

  sum_display_scanner #(.REFRESH_DIV(RD), .PAGE_HOLD(PH)) dut (
    .clk(clk), .rst_n(rst_n), .sum(sum), .cout(cout), .load(load),
    .auto_page(auto_page), .page_sel(page_sel),
    .seg_n(seg_n), .an_n(an_n), .dp_n(dp_n), .page_led(page_led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       led;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_no   = 0;

  // Expected-state model. It holds the DUT state before the next edge.
  int          k;
  logic [31:0] m_snap;
  logic        m_cout;
  logic        m_page;
  int          m_frame;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // One reset cycle: the outputs are expected at their reset values.
  task automatic rcyc();
    exp_t e;
    e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1; e.led = 1'b0;
    m_snap = '0; m_cout = 1'b0; m_page = 1'b0; m_frame = 0; k = 0;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // One operating cycle with the inputs as currently driven.
  task automatic cyc();
    exp_t        e;
    int          dv;
    int          dg;
    logic [15:0] pg;
    logic [3:0]  nb;
    dv = k % RD;
    dg = (k / RD) % 4;
    pg = m_page ? m_snap[31:16] : m_snap[15:0];
    nb = pg[dg*4 +: 4];
    e.an  = (dv == 0) ? 4'b1111 : ~(4'b0001 << dg);
    e.seg = glyph(nb);
`ifdef LEADING_ZERO_BLANK_EN
    if (dg != 0 && (pg >> (4*dg)) == 16'd0) e.seg = 7'b1111111;
`endif
    e.dp = !(dg == 3 && m_page && m_cout);
    if (load) begin m_snap = sum; m_cout = cout; end
    if (dv == RD-1 && dg == 3) begin
      if (auto_page) begin
        if (m_frame == PH-1) begin m_frame = 0; m_page = ~m_page; end
        else m_frame = m_frame + 1;
      end else begin
        m_frame = 0;
        m_page  = page_sel;
      end
    end
    e.led = m_page;
    k = k + 1;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Monitor: compares the outputs after every clock edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      cyc_no++;
      checks++;
      if (an_n !== e.an) begin
        failures++;
        $display("FAIL an_n cyc=%0d got=%b exp=%b", cyc_no, an_n, e.an);
      end
      checks++;
      if (seg_n !== e.seg) begin
        failures++;
        $display("FAIL seg_n cyc=%0d got=%b exp=%b", cyc_no, seg_n, e.seg);
      end
      checks++;
      if (dp_n !== e.dp) begin
        failures++;
        $display("FAIL dp_n cyc=%0d got=%b exp=%b", cyc_no, dp_n, e.dp);
      end
      checks++;
      if (page_led !== e.led) begin
        failures++;
        $display("FAIL page_led cyc=%0d got=%b exp=%b", cyc_no, page_led, e.led);
      end
    end
  end

  initial begin
    rst_n = 1'b0; sum = 32'hFFFF_FFFF; cout = 1'b1; load = 1'b1;
    auto_page = 1'b0; page_sel = 1'b0;
    @(negedge clk);

    // 1: reset overrides load; afterwards the snapshot is 0
    rcyc(); rcyc(); rcyc();
    rst_n = 1'b1; load = 1'b0;
    run(16);

    // 2: page 0 of 0x1234ABCD shows D,C,B,A
    sum = 32'h1234_ABCD; cout = 1'b0; load = 1'b1;
    cyc();
    load = 1'b0;
    run(31);

    // 3: page_sel is raised mid-frame; the page changes at the frame end
    run(5);
    page_sel = 1'b1;
    run(43);

    // 4: carry indicator on digit 3 of page 1, then page 0 shows 0000
    sum = 32'h8000_0000; cout = 1'b1; load = 1'b1;
    cyc();
    load = 1'b0;
    run(20);
    page_sel = 1'b0;
    run(32);

    // 5: automatic paging; page_sel has no effect
    auto_page = 1'b1;
    for (int i = 0; i < 10; i++) begin
      page_sel = ~page_sel;
      run(9);
    end

    // 6: leading-zero patterns
    auto_page = 1'b0; page_sel = 1'b0;
    sum = 32'h0000_000A; cout = 1'b0; load = 1'b1;
    cyc();
    load = 1'b0;
    run(40);
    sum = 32'h0000_0000; load = 1'b1;
    cyc();
    load = 1'b0;
    run(32);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
